// File: rtl/wb_register_file.sv
// Write-back stage of the MIPS pipeline: result select, 32-entry register file commit,
// two decode read ports with same-cycle W->D bypass, debug read port, commit counter and trace.
module wb_register_file #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int BYPASS      = 1,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   regWriteW,
    input  logic                   memToRegW,
    input  logic [DATA_WIDTH-1:0]  readDataW,
    input  logic [DATA_WIDTH-1:0]  aluOutW,
    input  logic [ADDR_WIDTH-1:0]  writeRegW,
    input  logic [ADDR_WIDTH-1:0]  ra1D,
    input  logic [ADDR_WIDTH-1:0]  ra2D,
    output logic [DATA_WIDTH-1:0]  rd1D,
    output logic [DATA_WIDTH-1:0]  rd2D,
    output logic [DATA_WIDTH-1:0]  resultW,
    input  logic [ADDR_WIDTH-1:0]  dbgAddr,
    output logic [DATA_WIDTH-1:0]  dbgData,
    output logic [COUNT_WIDTH-1:0] retireCount,
    output logic                   lastWrValid,
    output logic [ADDR_WIDTH-1:0]  lastWrAddr,
    output logic [DATA_WIDTH-1:0]  lastWrData
);

    localparam int  NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam bit  BYPASS_EN  = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  commit;
    logic                  bypass1;
    logic                  bypass2;

    // Result selection is purely combinational and independent of the write enable.
    always_comb begin
        resultW = memToRegW ? readDataW : aluOutW;
    end

    // Writes to r0 and writes under reset never commit, so r0 stays zero in storage.
    always_comb begin
        commit = regWriteW && (writeRegW != '0) && !RST;
    end

    always_comb begin
        bypass1 = BYPASS_EN && commit && (ra1D == writeRegW);
        bypass2 = BYPASS_EN && commit && (ra2D == writeRegW);
    end

    always_comb begin
        rd1D = '0;
        if (ra1D != '0) begin
            rd1D = bypass1 ? resultW : regs[ra1D];
        end
    end

    always_comb begin
        rd2D = '0;
        if (ra2D != '0) begin
            rd2D = bypass2 ? resultW : regs[ra2D];
        end
    end

    // Debug port shows storage only; a W-stage write in flight is not visible here yet.
    always_comb begin
        dbgData = '0;
        if (dbgAddr != '0) begin
            dbgData = regs[dbgAddr];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[writeRegW] <= resultW;
        end
    end

    // Counter wraps silently at its width.
    always_ff @(posedge CLK) begin
        if (RST) begin
            retireCount <= '0;
        end else if (commit) begin
            retireCount <= retireCount + COUNT_WIDTH'(1);
        end
    end

    // Trace: valid pulses for one cycle per commit; address/data hold between commits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lastWrValid <= 1'b0;
            lastWrAddr  <= '0;
            lastWrData  <= '0;
        end else if (commit) begin
            lastWrValid <= 1'b1;
            lastWrAddr  <= writeRegW;
            lastWrData  <= resultW;
        end else begin
            lastWrValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_register_file.sv
// Bench for wb_register_file: three instances (default, no bypass, 4-bit counter) share one
// stimulus stream and are compared every cycle against an array-based reference model.
module tb_wb_register_file;

    logic        CLK;
    logic        RST;
    logic        regWriteW;
    logic        memToRegW;
    logic [31:0] readDataW;
    logic [31:0] aluOutW;
    logic [4:0]  writeRegW;
    logic [4:0]  ra1D;
    logic [4:0]  ra2D;
    logic [4:0]  dbgAddr;

    logic [31:0] rd1_a, rd2_a, res_a, dbg_a, lwd_a, cnt_a;
    logic [4:0]  lwa_a;
    logic        lwv_a;
    logic [31:0] rd1_b, rd2_b, res_b, dbg_b, lwd_b, cnt_b;
    logic [4:0]  lwa_b;
    logic        lwv_b;
    logic [31:0] rd1_c, rd2_c, res_c, dbg_c, lwd_c;
    logic [3:0]  cnt_c;
    logic [4:0]  lwa_c;
    logic        lwv_c;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] m_count;
    logic        m_lv;
    logic [4:0]  m_la;
    logic [31:0] m_ld;
    logic [36:0] exp_q[$];

    wb_register_file u_dut (
        .CLK(CLK), .RST(RST), .regWriteW(regWriteW), .memToRegW(memToRegW),
        .readDataW(readDataW), .aluOutW(aluOutW), .writeRegW(writeRegW),
        .ra1D(ra1D), .ra2D(ra2D), .rd1D(rd1_a), .rd2D(rd2_a), .resultW(res_a),
        .dbgAddr(dbgAddr), .dbgData(dbg_a), .retireCount(cnt_a),
        .lastWrValid(lwv_a), .lastWrAddr(lwa_a), .lastWrData(lwd_a)
    );

    wb_register_file #(.BYPASS(0)) u_nobyp (
        .CLK(CLK), .RST(RST), .regWriteW(regWriteW), .memToRegW(memToRegW),
        .readDataW(readDataW), .aluOutW(aluOutW), .writeRegW(writeRegW),
        .ra1D(ra1D), .ra2D(ra2D), .rd1D(rd1_b), .rd2D(rd2_b), .resultW(res_b),
        .dbgAddr(dbgAddr), .dbgData(dbg_b), .retireCount(cnt_b),
        .lastWrValid(lwv_b), .lastWrAddr(lwa_b), .lastWrData(lwd_b)
    );

    wb_register_file #(.COUNT_WIDTH(4)) u_cnt4 (
        .CLK(CLK), .RST(RST), .regWriteW(regWriteW), .memToRegW(memToRegW),
        .readDataW(readDataW), .aluOutW(aluOutW), .writeRegW(writeRegW),
        .ra1D(ra1D), .ra2D(ra2D), .rd1D(rd1_c), .rd2D(rd2_c), .resultW(res_c),
        .dbgAddr(dbgAddr), .dbgData(dbg_c), .retireCount(cnt_c),
        .lastWrValid(lwv_c), .lastWrAddr(lwa_c), .lastWrData(lwd_c)
    );

    // Clock / reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model helpers, written from the behavioural rules rather than the RTL structure.
    function automatic logic [31:0] m_result();
        return memToRegW ? readDataW : aluOutW;
    endfunction

    function automatic bit m_commit();
        return regWriteW && (writeRegW != 5'd0) && !RST;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && m_commit() && a == writeRegW) return m_result();
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_count = 32'd0;
        m_lv = 1'b0;
        m_la = 5'd0;
        m_ld = 32'd0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        if (RST) begin
            model_reset();
        end else if (m_commit()) begin
            m_regs[writeRegW] = m_result();
            m_count = m_count + 32'd1;
            m_lv = 1'b1;
            m_la = writeRegW;
            m_ld = m_result();
            exp_q.push_back({writeRegW, m_result()});
        end else begin
            m_lv = 1'b0;
        end
    endtask

    // Driver: inputs change on the falling edge and settle before checking.
    task automatic drive(input bit rst_i, input bit we, input bit m2r, input logic [31:0] rdat,
                         input logic [31:0] alu, input logic [4:0] wa, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] da);
        RST = rst_i;
        regWriteW = we;
        memToRegW = m2r;
        readDataW = rdat;
        aluOutW = alu;
        writeRegW = wa;
        ra1D = a1;
        ra2D = a2;
        dbgAddr = da;
        #1;
    endtask

    // Scoreboard: compare all outputs with the model, then advance both across one edge.
    task automatic cycle();
        logic [36:0] item;
        check_eq("result", res_a, m_result());
        check_eq("rd1", rd1_a, m_read(ra1D, 1'b1));
        check_eq("rd2", rd2_a, m_read(ra2D, 1'b1));
        check_eq("dbg", dbg_a, m_read(dbgAddr, 1'b0));
        check_eq("count", cnt_a, m_count);
        check_eq("last_valid", lwv_a, m_lv);
        check_eq("last_addr", lwa_a, m_la);
        check_eq("last_data", lwd_a, m_ld);
        check_eq("nobyp_rd1", rd1_b, m_read(ra1D, 1'b0));
        check_eq("nobyp_rd2", rd2_b, m_read(ra2D, 1'b0));
        check_eq("cnt4_count", cnt_c, m_count[3:0]);
        check_eq("cnt4_dbg", dbg_c, m_read(dbgAddr, 1'b0));
        if (m_lv) begin
            if (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                check_eq("trace_q", {lwa_a, lwd_a}, item);
            end
        end
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic reset_dut();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        model_reset();
        @(negedge CLK);
    endtask

    logic [31:0] last_r1;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        reset_dut();

        // Every register reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i));
            check_eq("reset_dbg", dbg_a, 32'd0);
            cycle();
        end
        check_eq("reset_count", cnt_a, 32'd0);

        // ALU write to r5, then read it back through storage.
        drive(0, 1, 0, 32'hDEAD_0000, 32'h1234_5678, 5'd5, 5'd0, 5'd0, 5'd0);
        cycle();
        drive(0, 0, 0, 0, 0, 5'd0, 5'd5, 5'd0, 5'd5);
        check_eq("r5_rd1", rd1_a, 32'h1234_5678);
        check_eq("r5_last_valid", lwv_a, 1'b1);
        check_eq("r5_last_addr", lwa_a, 5'd5);
        check_eq("r5_count", cnt_a, 32'd1);
        cycle();

        // Same-cycle bypass of a load into r9; no-bypass instance still sees the old value.
        drive(0, 1, 1, 32'hDEAD_BEEF, 32'h0000_1111, 5'd9, 5'd0, 5'd9, 5'd9);
        check_eq("byp_rd2", rd2_a, 32'hDEAD_BEEF);
        check_eq("nobyp_rd2_old", rd2_b, 32'd0);
        check_eq("byp_dbg_storage", dbg_a, 32'd0);
        cycle();

        // Write to r0 is discarded.
        drive(0, 1, 0, 0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 5'd0);
        check_eq("r0_rd1", rd1_a, 32'd0);
        cycle();
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        check_eq("r0_count", cnt_a, 32'd2);
        check_eq("r0_last_valid", lwv_a, 1'b0);
        cycle();

        // Reset wins over a simultaneous write.
        drive(0, 1, 0, 0, 32'h0000_A5A5, 5'd3, 5'd3, 5'd0, 5'd0);
        cycle();
        drive(1, 1, 0, 0, 32'h0000_5A5A, 5'd4, 5'd3, 5'd4, 5'd3);
        check_eq("rst_no_bypass", rd2_a, 32'd0);
        cycle();
        drive(0, 0, 0, 0, 0, 5'd0, 5'd3, 5'd4, 5'd4);
        check_eq("rst_r3", rd1_a, 32'd0);
        check_eq("rst_r4", rd2_a, 32'd0);
        check_eq("rst_count", cnt_a, 32'd0);
        check_eq("rst_last_valid", lwv_a, 1'b0);
        cycle();

        // Seventeen commits wrap the 4-bit counter to one.
        reset_dut();
        last_r1 = 32'd0;
        for (int i = 0; i < 17; i++) begin
            last_r1 = $urandom;
            drive(0, 1, 0, 0, last_r1, 5'd1, 5'd1, 5'd2, 5'd1);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd1, 5'd1);
        check_eq("wrap_cnt4", cnt_c, 4'd1);
        check_eq("wrap_cnt32", cnt_a, 32'd17);
        check_eq("wrap_r1", dbg_c, last_r1);
        cycle();

        // Random traffic with address aliasing and occasional reset.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
